// File: rtl/mips_control_sequencer.sv
// Multicycle control sequencer for the MIPS datapath: fetch, decode,
// execute and memory-wait sequencing with a memory-timeout trap.
// Optional feature macro: SEQ_PERF_CNT_EN (retired-instruction counter).
module mips_control_sequencer #(
    parameter int unsigned MOC_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  state_sel,
    input  logic        cond,
    input  logic        mem_moc,
    output logic [6:0]  state,
    output logic        mem_en,
    output logic        mem_rw,
    output logic        mar_ld,
    output logic        ir_ld,
    output logic        mdr_ld,
    output logic        pc_ld,
    output logic        npc_ld,
    output logic        rf_ld,
    output logic        bus_err,
    output logic [31:0] instr_retired
);

    typedef enum logic [6:0] {
        S_RESET      = 7'd0,
        S_FETCH      = 7'd1,
        S_FETCH_WAIT = 7'd2,
        S_DECODE     = 7'd3,
        S_ALU        = 7'd6,
        S_STORE      = 7'd7,
        S_STORE_WAIT = 7'd8,
        S_BR_A       = 7'd11,
        S_BR_TAKEN   = 7'd12,
        S_LOAD       = 7'd13,
        S_LOAD_WAIT  = 7'd14,
        S_LOAD_WB    = 7'd15,
        S_ALU_LO     = 7'd17,
        S_ALU_HI     = 7'd35,
        S_BR_B       = 7'd37,
        S_BR_C       = 7'd39,
        S_BR_D       = 7'd41,
        S_BR_E       = 7'd42,
        S_JR         = 7'd44,
        S_ERROR      = 7'd63
    } state_t;

    localparam int unsigned CW = (MOC_TIMEOUT > 2) ? $clog2(MOC_TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(MOC_TIMEOUT - 1);

    state_t          state_q, state_d;
    logic [CW-1:0]   wait_cnt, wait_cnt_d;
    logic            retire;
    logic            timeout;

    function automatic logic is_alu(input logic [6:0] s);
        return (s == 7'd6) || ((s >= 7'd17) && (s <= 7'd35));
    endfunction

    function automatic logic is_branch(input logic [6:0] s);
        return (s == 7'd11) || (s == 7'd37) || (s == 7'd39) ||
               (s == 7'd41) || (s == 7'd42);
    endfunction

    // Only these targets are real execute states; anything else refetches.
    function automatic logic dispatch_ok(input logic [6:0] s);
        return is_alu(s) || is_branch(s) || (s == 7'd7) ||
               (s == 7'd13) || (s == 7'd44);
    endfunction

    function automatic logic is_wait(input logic [6:0] s);
        return (s == 7'd2) || (s == 7'd8) || (s == 7'd14);
    endfunction

    assign timeout = (wait_cnt == CNT_LAST);

    // Next-state, retire and strobe decode from the current state.
    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        mem_en  = 1'b0;
        mem_rw  = 1'b0;
        mar_ld  = 1'b0;
        ir_ld   = 1'b0;
        mdr_ld  = 1'b0;
        pc_ld   = 1'b0;
        npc_ld  = 1'b0;
        rf_ld   = 1'b0;
        bus_err = 1'b0;
        case (state_q)
            S_RESET: state_d = S_FETCH;
            S_FETCH: begin
                mar_ld  = 1'b1;
                state_d = S_FETCH_WAIT;
            end
            S_FETCH_WAIT: begin
                mem_en = 1'b1;
                mem_rw = 1'b1;
                ir_ld  = mem_moc;
                if (mem_moc)      state_d = S_DECODE;
                else if (timeout) state_d = S_ERROR;
            end
            S_DECODE: begin
                pc_ld   = 1'b1;
                npc_ld  = 1'b1;
                state_d = dispatch_ok(state_sel) ? state_t'(state_sel) : S_FETCH;
            end
            S_STORE: begin
                mar_ld  = 1'b1;
                state_d = S_STORE_WAIT;
            end
            S_STORE_WAIT: begin
                mem_en = 1'b1;
                if (mem_moc) begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end else if (timeout) begin
                    state_d = S_ERROR;
                end
            end
            S_LOAD: begin
                mar_ld  = 1'b1;
                state_d = S_LOAD_WAIT;
            end
            S_LOAD_WAIT: begin
                mem_en = 1'b1;
                mem_rw = 1'b1;
                mdr_ld = mem_moc;
                if (mem_moc)      state_d = S_LOAD_WB;
                else if (timeout) state_d = S_ERROR;
            end
            S_LOAD_WB: begin
                rf_ld   = 1'b1;
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_BR_TAKEN, S_JR: begin
                pc_ld   = 1'b1;
                npc_ld  = 1'b1;
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_BR_A, S_BR_B, S_BR_C, S_BR_D, S_BR_E: begin
                state_d = cond ? S_BR_TAKEN : S_FETCH;
                retire  = ~cond;
            end
            S_ERROR: bus_err = 1'b1;
            default: begin
                // ALU range 17..35 is mostly unnamed, so it is decoded here.
                state_d = S_FETCH;
                if (is_alu(state_q)) begin
                    rf_ld  = 1'b1;
                    retire = 1'b1;
                end
            end
        endcase
    end

    // Wait counter runs only while a wait state holds; any transition clears it.
    always_comb begin
        wait_cnt_d = '0;
        if (is_wait(state_q) && (state_d == state_q))
            wait_cnt_d = wait_cnt + 1'b1;
    end

    // State and wait-counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_RESET;
            wait_cnt <= '0;
        end else begin
            state_q  <= state_d;
            wait_cnt <= wait_cnt_d;
        end
    end

    assign state = state_q;

`ifdef SEQ_PERF_CNT_EN
    logic [31:0] retired_q;

    // Retired-instruction counter, wraps naturally at 2^32.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)       retired_q <= '0;
        else if (retire) retired_q <= retired_q + 32'd1;
    end

    assign instr_retired = retired_q;
`else
    logic unused_retire;
    assign unused_retire = retire;
    assign instr_retired = '0;
`endif

endmodule
